// File: rtl/gpu_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_uart_pkg
// Description : Shared definitions for the GPU UART blocks: receiver FSM
//               state encoding and the nominal bit period at the 20 MHz
//               core clock (20 MHz / 115200 baud, rounded).
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_uart_pkg;

    localparam int UART_CLKS_PER_BIT_20MHZ = 174;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/gpu_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gpu_byte_fifo
// Description : 2-entry, 8-bit, single-clock FIFO. Head/tail register pair,
//               valid/ready read side, push write side with a registered
//               one-cycle overrun pulse when a push is refused.
// Ports       : clk, rst_n         - core clock, async active-low reset
//               push, push_data    - write request and byte
//               data_out           - head byte (holds while empty)
//               data_valid_out     - FIFO non-empty (registered)
//               data_ready_in      - consumer accepts head
//               overrun_out        - pulse: push dropped because full
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_byte_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic [7:0] data_out,
    output logic       data_valid_out,
    input  logic       data_ready_in,
    output logic       overrun_out
);

    logic [1:0] r_count;
    logic [7:0] r_head;
    logic [7:0] r_tail;
    logic       r_overrun;

    logic w_pop;
    logic w_full;
    logic w_drop;
    logic w_push_ok;

    assign w_pop     = (r_count != 2'd0) && data_ready_in;
    assign w_full    = (r_count == 2'd2);
    // A push into a full FIFO survives only if the head leaves this cycle.
    assign w_drop    = push && w_full && !w_pop;
    assign w_push_ok = push && !w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_head    <= 8'h00;
            r_tail    <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            case ({w_push_ok, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= push_data;
                    else                 r_tail <= push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Head is only replaced when a second entry exists, so
                    // data_out keeps the last byte once the FIFO drains.
                    if (r_count == 2'd2) r_head <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out       = r_head;
    assign data_valid_out = (r_count != 2'd0);
    assign overrun_out    = r_overrun;

endmodule
`default_nettype wire

// File: rtl/gpu_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : gpu_uart_rx
// Description : 8N1 UART receiver for the tiniest-GPU command stream. Two-FF
//               synchroniser, mid-bit sampling, start/stop validation,
//               break absorption, 2-entry output FIFO.
// Ports       : clk, rst_n         - core clock, async active-low reset
//               rx                 - raw asynchronous UART line (idle high)
//               data_out           - received byte at FIFO head
//               data_valid_out     - FIFO non-empty
//               data_ready_in      - consumer accepts head
//               frame_err_out      - pulse: stop bit sampled low
//               overrun_out        - pulse: good byte dropped, FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_uart_rx
    import gpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_20MHZ,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid_out,
    input  logic       data_ready_in,
    output logic       frame_err_out,
    output logic       overrun_out
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(HALF_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(CLKS_PER_BIT - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic [1:0]          r_sync_fill;
    logic                r_armed;
    uart_rx_state_e      r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shreg;
    logic                r_frame_err;

    uart_rx_state_e      w_state_n;
    logic [c_CNT_W-1:0]  w_cnt_n;
    logic [2:0]          w_bit_idx_n;
    logic [7:0]          w_shreg_n;
    logic                w_push;
    logic                w_frame_err;
    logic                w_rx_s;

    assign w_rx_s = r_sync2;

    // The synchroniser flops reset to idle-high, so their contents say
    // nothing about the pin until two edges after reset. r_sync_fill marks
    // when w_rx_s really reflects the line; only then may a high level arm
    // the receiver. This keeps a line still low after a mid-frame reset
    // from being taken as a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_fill <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_armed     <= r_armed | (r_sync_fill[1] & w_rx_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shreg     <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_bit_idx   <= w_bit_idx_n;
            r_shreg     <= w_shreg_n;
            r_frame_err <= w_frame_err;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt + c_CNT_W'(1);
        w_bit_idx_n = r_bit_idx;
        w_shreg_n   = r_shreg;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (r_armed && !w_rx_s) w_state_n = START;
            end
            START: begin
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_n     = '0;
                    w_bit_idx_n = 3'd0;
                    w_state_n   = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == c_CNT_FULL) begin
                    w_cnt_n              = '0;
                    w_shreg_n[r_bit_idx] = w_rx_s;
                    w_bit_idx_n          = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_n = STOP;
                end
            end
            STOP: begin
                // Leaving at the stop-bit centre puts IDLE half a bit ahead
                // of the next possible start edge.
                if (r_cnt == c_CNT_FULL) begin
                    w_cnt_n = '0;
                    if (w_rx_s) begin
                        w_push    = 1'b1;
                        w_state_n = IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_n   = BREAK;
                    end
                end
            end
            BREAK: begin
                w_cnt_n = '0;
                if (w_rx_s) w_state_n = IDLE;
            end
            default: begin
                w_cnt_n   = '0;
                w_state_n = IDLE;
            end
        endcase
    end

    assign frame_err_out = r_frame_err;

    gpu_byte_fifo u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (w_push),
        .push_data      (r_shreg_push_data()),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .overrun_out    (overrun_out)
    );

    // The last data bit lands in r_shreg on the same edge as the move to
    // STOP, so by the stop sample r_shreg already holds the whole byte.
    function automatic logic [7:0] r_shreg_push_data();
        return r_shreg;
    endfunction

endmodule
`default_nettype wire

// File: tb/tb_gpu_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_uart_rx
// Description : Self-checking bench for gpu_uart_rx at 8 clocks per bit.
//               Directed corner sequences, a vector table and a randomized
//               frame stream compared against a byte-queue reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_uart_rx;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic       data_ready_in;
    logic       frame_err_out;
    logic       overrun_out;

    gpu_uart_rx #(.CLKS_PER_BIT(C), .HALF_BIT(C / 2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx             (rx),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .frame_err_out  (frame_err_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of the output side, sampled mid-cycle.
    logic [7:0] acc_q[$];
    int         acc_cyc[$];
    int         vcount   = 0;
    int         ferr_n   = 0;
    int         ovr_n    = 0;
    int         ferr_cyc = 0;
    int         ovr_cyc  = 0;

    always @(negedge clk) begin
        if (data_valid_out) vcount <= vcount + 1;
        if (data_valid_out && data_ready_in) begin
            acc_q.push_back(data_out);
            acc_cyc.push_back(cyc);
        end
        if (frame_err_out) begin
            ferr_n   <= ferr_n + 1;
            ferr_cyc <= cyc;
        end
        if (overrun_out) begin
            ovr_n   <= ovr_n + 1;
            ovr_cyc <= cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        rx = 1'b0;
        t0 = cyc;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(C);
        end
        rx = stop_bit;
        tick(C);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         t0, t1, t2, t3;
    int         b_acc, b_v, b_ferr, b_ovr, exp_ferr;
    bit         rnd_done;
    logic [7:0] rb;
    logic       rok;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 0};
        vecs[2] = '{8'h55, 1'b1, 1, 0};
        vecs[3] = '{8'h80, 1'b0, 0, 1};
        vecs[4] = '{8'hC3, 1'b1, 1, 0};
        vecs[5] = '{8'h7E, 1'b0, 0, 1};

        rst_n = 1'b0;
        rx = 1'b1;
        data_ready_in = 1'b0;
        tick(3);
        chk("reset data_out", data_out, 8'h00);
        chk("reset valid", data_valid_out, 0);
        chk("reset frame_err", frame_err_out, 0);
        chk("reset overrun", overrun_out, 0);
        rst_n = 1'b1;
        tick(6);

        // Single byte, exact latency and one-cycle valid.
        data_ready_in = 1'b1;
        b_acc = acc_q.size(); b_v = vcount;
        send_frame(8'hA5, 1'b1, t0);
        rx = 1'b1;
        tick(10);
        chk("A5 count", acc_q.size() - b_acc, 1);
        if (acc_q.size() > b_acc) begin
            chk("A5 data", acc_q[b_acc], 8'hA5);
            chk("A5 latency", acc_cyc[b_acc] - t0, 79);
        end
        chk("A5 valid cycles", vcount - b_v, 1);
        chk("A5 no ferr", ferr_n, 0);
        chk("A5 no ovr", ovr_n, 0);

        // Start glitch.
        b_acc = acc_q.size(); b_v = vcount;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(40);
        chk("glitch valid", vcount - b_v, 0);
        chk("glitch ferr", ferr_n, 0);
        chk("glitch ovr", ovr_n, 0);

        // Bad stop bit followed by a long break, then a good frame.
        b_acc = acc_q.size(); b_ferr = ferr_n;
        send_frame(8'h3C, 1'b0, t0);
        tick(100);
        chk("break ferr once", ferr_n - b_ferr, 1);
        chk("break ferr timing", ferr_cyc - t0, 79);
        chk("break no byte", acc_q.size() - b_acc, 0);
        rx = 1'b1;
        tick(4);
        send_frame(8'h11, 1'b1, t0);
        rx = 1'b1;
        tick(6);
        chk("after break count", acc_q.size() - b_acc, 1);
        if (acc_q.size() > b_acc) chk("after break data", acc_q[b_acc], 8'h11);
        chk("after break ferr", ferr_n - b_ferr, 1);

        // Vector table.
        foreach (vecs[k]) begin
            b_acc = acc_q.size(); b_ferr = ferr_n;
            send_frame(vecs[k].data, vecs[k].stop_bit, t0);
            rx = 1'b1;
            tick(6);
            chk($sformatf("vec%0d bytes", k), acc_q.size() - b_acc, vecs[k].exp_bytes);
            chk($sformatf("vec%0d ferr", k), ferr_n - b_ferr, vecs[k].exp_ferr);
            if (vecs[k].exp_bytes == 1 && acc_q.size() > b_acc)
                chk($sformatf("vec%0d data", k), acc_q[b_acc], vecs[k].data);
        end

        // Three back-to-back bytes, consumer stalled: third is dropped.
        data_ready_in = 1'b0;
        b_acc = acc_q.size(); b_ovr = ovr_n;
        send_frame(8'h01, 1'b1, t1);
        send_frame(8'h02, 1'b1, t2);
        send_frame(8'h03, 1'b1, t3);
        rx = 1'b1;
        tick(4);
        chk("ovr valid held", data_valid_out, 1);
        chk("ovr head", data_out, 8'h01);
        chk("ovr pulses", ovr_n - b_ovr, 1);
        chk("ovr timing", ovr_cyc - t3, 79);
        data_ready_in = 1'b1;
        tick(5);
        chk("ovr drained count", acc_q.size() - b_acc, 2);
        if (acc_q.size() >= b_acc + 2) begin
            chk("ovr drained 0", acc_q[b_acc], 8'h01);
            chk("ovr drained 1", acc_q[b_acc + 1], 8'h02);
        end
        chk("empty holds data", data_out, 8'h02);
        chk("empty valid", data_valid_out, 0);

        // Full FIFO popped on the exact cycle of the third push.
        data_ready_in = 1'b0;
        b_acc = acc_q.size(); b_ovr = ovr_n;
        fork
            begin
                send_frame(8'h01, 1'b1, t1);
                send_frame(8'h02, 1'b1, t2);
                send_frame(8'h03, 1'b1, t3);
            end
            begin
                tick(2 * 10 * C + 78);
                data_ready_in = 1'b1;
            end
        join
        rx = 1'b1;
        tick(6);
        chk("pop-push no ovr", ovr_n - b_ovr, 0);
        chk("pop-push count", acc_q.size() - b_acc, 3);
        if (acc_q.size() >= b_acc + 3) begin
            chk("pop-push 0", acc_q[b_acc], 8'h01);
            chk("pop-push 1", acc_q[b_acc + 1], 8'h02);
            chk("pop-push 2", acc_q[b_acc + 2], 8'h03);
        end

        // Randomized frames with a randomly stalling consumer.
        b_acc = acc_q.size(); b_ferr = ferr_n; b_ovr = ovr_n;
        exp_q.delete();
        exp_ferr = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 14; k++) begin
                    rb  = 8'($urandom);
                    rok = ($urandom_range(0, 4) != 0);
                    if (rok) exp_q.push_back(rb);
                    else     exp_ferr++;
                    send_frame(rb, rok, t0);
                    rx = 1'b1;
                    tick($urandom_range(1, 20));
                end
                tick(20);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    data_ready_in = 1'($urandom_range(0, 1));
                    tick(1);
                end
                data_ready_in = 1'b1;
            end
        join
        tick(6);
        chk("rand count", acc_q.size() - b_acc, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (b_acc + k < acc_q.size())
                chk($sformatf("rand byte %0d", k), acc_q[b_acc + k], exp_q[k]);
        end
        chk("rand ferr", ferr_n - b_ferr, exp_ferr);
        chk("rand ovr", ovr_n - b_ovr, 0);

        // Reset during data bit 3 of 0x5A, line low after release.
        data_ready_in = 1'b1;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 3; i++) begin
            rx = (8'h5A >> i) & 1;
            tick(C);
        end
        rx = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("async rst data", data_out, 8'h00);
        chk("async rst valid", data_valid_out, 0);
        chk("async rst ferr", frame_err_out, 0);
        rx = 1'b0;
        tick(2);
        rst_n = 1'b1;
        b_acc = acc_q.size(); b_ferr = ferr_n;
        tick(40);
        chk("post-rst low no byte", acc_q.size() - b_acc, 0);
        rx = 1'b1;
        tick(20);
        send_frame(8'h96, 1'b1, t0);
        rx = 1'b1;
        tick(6);
        chk("post-rst count", acc_q.size() - b_acc, 1);
        if (acc_q.size() > b_acc) chk("post-rst data", acc_q[b_acc], 8'h96);
        chk("post-rst ferr", ferr_n - b_ferr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
